// File: rtl/npcnn_pkg.sv
// npcnn_pkg: constants and types shared by the convolution datapath and the
// pooling stage.
//   NPCNN_DW  default result width (signed two's complement)
//   NPCNN_OS  default side of the square convolution result map
//   NPCNN_PS  default pooling window side / stride
//   npcnn_result_t  signed convolution result
//   npcnn_op()      number of pooled rows/columns produced (floor(os/ps))
package npcnn_pkg;

    localparam int NPCNN_DW = 20;
    localparam int NPCNN_OS = 4;
    localparam int NPCNN_PS = 2;

    typedef logic signed [NPCNN_DW-1:0] npcnn_result_t;

    function automatic int npcnn_op(input int os, input int ps);
        return os / ps;
    endfunction

endpackage

// File: rtl/npcnn_relu_max.sv
// npcnn_relu_max: combinational signed max of a running maximum and a new
// operand. The new operand optionally passes through ReLU first.
// Configuration macro: NPCNN_POOL_RELU_EN (defined -> negative nxt forced to 0).
// Ports:
//   cur  in   DW  running window maximum (signed)
//   nxt  in   DW  incoming element (signed)
//   val  out  DW  nxt after optional ReLU
//   mx   out  DW  signed max(cur, val)
module npcnn_relu_max
    import npcnn_pkg::*;
#(
    parameter int DW = NPCNN_DW
) (
    input  logic signed [DW-1:0] cur,
    input  logic signed [DW-1:0] nxt,
    output logic signed [DW-1:0] val,
    output logic signed [DW-1:0] mx
);

    always_comb begin
        val = nxt;
`ifdef NPCNN_POOL_RELU_EN
        if (nxt[DW-1]) begin
            val = '0;
        end
`endif
        mx = (val > cur) ? val : cur;
    end

endmodule

// File: rtl/npcnn_pool.sv
// npcnn_pool: streaming ReLU + non-overlapping max-pooling stage. Consumes a
// row-major OSxOS signed result map, emits the OPxOP pooled map row-major.
// A one-row line buffer holds the running window maxima.
// Configuration macro: NPCNN_POOL_RELU_EN (ReLU on inputs, via npcnn_relu_max).
// Ports:
//   clk         in   1   clock, rising edge
//   rst         in   1   synchronous active-high reset
//   clr         in   1   synchronous frame abort (wins over a same-cycle beat)
//   in_data     in   DW  convolution result element (signed)
//   in_valid    in   1   in_data presented
//   in_ready    out  1   stage can accept a beat
//   out_data    out  DW  pooled element (signed)
//   out_valid   out  1   out_data valid, held until out_ready
//   out_ready   in   1   consumer accepts out_data
//   frame_done  out  1   one-cycle pulse after the last beat of a frame
module npcnn_pool
    import npcnn_pkg::*;
#(
    parameter int DW = NPCNN_DW,
    parameter int OS = NPCNN_OS,
    parameter int PS = NPCNN_PS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_done
);

    localparam int OP = npcnn_op(OS, PS);
    localparam int CW = $clog2(OS + 1);
    localparam int IW = (OP > 1) ? $clog2(OP) : 1;
    localparam logic [CW-1:0] LAST  = CW'(OS - 1);
    localparam logic [CW-1:0] PLAST = CW'(PS - 1);
    localparam logic [CW-1:0] SPAN  = CW'(OP * PS);

    // r/c are the frame position; pr/pc are r%PS and c%PS and ci is c/PS,
    // all kept as counters alongside r/c so no divider is needed.
    logic [CW-1:0] r, c, pr, pc, ci;
    logic [IW-1:0] li;
    logic signed [DW-1:0] lb [0:(1<<IW)-1];

    logic acc, in_win, first, win_last, at_end;
    logic signed [DW-1:0] val, mx;

    assign in_ready = !rst && (!out_valid || out_ready);
    assign acc      = in_valid && in_ready;
    assign li       = ci[IW-1:0];
    assign in_win   = (r < SPAN) && (c < SPAN);
    assign first    = (pr == '0) && (pc == '0);
    assign win_last = in_win && (pr == PLAST) && (pc == PLAST);
    assign at_end   = (r == LAST) && (c == LAST);

    npcnn_relu_max #(.DW(DW)) u_relu_max (
        .cur (lb[li]),
        .nxt (in_data),
        .val (val),
        .mx  (mx)
    );

    // Line buffer needs no reset: each slot is overwritten by the first beat
    // of every window before it is read.
    always_ff @(posedge clk) begin
        if (!rst && !clr && acc && in_win) begin
            lb[li] <= first ? val : mx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r          <= '0;
            c          <= '0;
            pr         <= '0;
            pc         <= '0;
            ci         <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= acc && at_end;

            if (acc && win_last) begin
                out_data  <= mx;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (acc) begin
                if (c == LAST) begin
                    c  <= '0;
                    pc <= '0;
                    ci <= '0;
                    if (r == LAST) begin
                        r  <= '0;
                        pr <= '0;
                    end else begin
                        r  <= r + 1'b1;
                        pr <= (pr == PLAST) ? '0 : pr + 1'b1;
                    end
                end else begin
                    c <= c + 1'b1;
                    if (pc == PLAST) begin
                        pc <= '0;
                        ci <= ci + 1'b1;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_npcnn_pool.sv
// Scoreboard bench for npcnn_pool: two instances (OS=4 and OS=5, PS=2).
// Stimulus pushes expected pooled values computed from the whole window of
// stored frame elements; a monitor pops and compares on each output handshake.
module tb_npcnn_pool;

    localparam int DW = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic signed [DW-1:0] got,
                       input logic signed [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] x);
`ifdef NPCNN_POOL_RELU_EN
        return (x < 0) ? '0 : x;
`else
        return x;
`endif
    endfunction

    for (genvar g = 0; g < 2; g++) begin : h
        localparam int OS = (g == 0) ? 4 : 5;
        localparam int PS = 2;
        localparam int OP = OS / PS;

        logic rst, clr, in_valid, in_ready, out_valid, out_ready, frame_done;
        logic signed [DW-1:0] in_data, out_data;

        npcnn_pool #(.DW(DW), .OS(OS), .PS(PS)) dut (
            .clk        (clk),
            .rst        (rst),
            .clr        (clr),
            .in_data    (in_data),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .out_data   (out_data),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .frame_done (frame_done)
        );

        // reference model state
        int pos = 0;
        logic signed [DW-1:0] frm [OS*OS];
        logic signed [DW-1:0] expq [$];
        logic ov_m = 1'b0;
        logic fd_next = 1'b0;
        logic fd_cur = 1'b0;
        int cyc = 0;
        int last_fd_cyc = 0;
        int fd_gap = 0;
        logic fin = 1'b0;

        function automatic logic signed [DW-1:0] win_max(input int r, input int c);
            logic signed [DW-1:0] m, x;
            m = relu(frm[(r - PS + 1) * OS + (c - PS + 1)]);
            for (int i = 0; i < PS; i++) begin
                for (int j = 0; j < PS; j++) begin
                    x = relu(frm[(r - PS + 1 + i) * OS + (c - PS + 1 + j)]);
                    if (x > m) m = x;
                end
            end
            return m;
        endfunction

        task automatic step(input logic v, input logic signed [DW-1:0] d, input logic ordy,
                            input logic r_, input logic c_, output logic acc);
            logic exp_rdy, completes;
            int rr, cc;
            @(negedge clk);
            rst = r_; clr = c_; in_valid = v; in_data = d; out_ready = ordy;
            #1;
            exp_rdy = !r_ && (!ov_m || ordy);
            chk("in_ready", in_ready, exp_rdy);
            chk("out_valid", out_valid, ov_m);
            acc = v && exp_rdy && !c_;
            fd_next = 1'b0;
            completes = 1'b0;
            if (r_ || c_) begin
                pos = 0;
            end else if (acc) begin
                rr = pos / OS;
                cc = pos % OS;
                frm[pos] = d;
                if (rr < OP * PS && cc < OP * PS && rr % PS == PS - 1 && cc % PS == PS - 1) begin
                    expq.push_back(win_max(rr, cc));
                    completes = 1'b1;
                end
                fd_next = (pos == OS * OS - 1);
                pos = (pos + 1) % (OS * OS);
            end
            if (r_ || c_) ov_m = 1'b0;
            else if (completes) ov_m = 1'b1;
            else if (ov_m && ordy) ov_m = 1'b0;
        endtask

        task automatic send(input logic signed [DW-1:0] d, input logic rnd);
            logic acc, v, ordy;
            int tries;
            acc = 1'b0;
            tries = 0;
            while (!acc && tries < 200) begin
                v = rnd ? ($urandom_range(3) != 0) : 1'b1;
                ordy = rnd ? ($urandom_range(3) != 0) : 1'b1;
                step(v, d, ordy, 1'b0, 1'b0, acc);
                tries++;
            end
            if (!acc) chk("beat_timeout", DW'(tries), 0);
        endtask

        task automatic idle(input int n);
            logic acc;
            for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
        endtask

        task automatic ramp(input int base);
            for (int i = 0; i < OS * OS; i++) send(DW'(base + i), 1'b0);
        endtask

        task automatic rand_frames(input int n);
            for (int f = 0; f < n; f++)
                for (int i = 0; i < OS * OS; i++)
                    send(DW'($urandom_range(2000)) - DW'(1000), 1'b1);
        endtask

        task automatic init();
            rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_in_ready", in_ready, 0);
        endtask

        task automatic finish_block();
            idle(12);
            chk("queue_empty", DW'(expq.size()), 0);
            fin = 1'b1;
        endtask

        // monitor: output handshakes and frame_done timing
        always begin
            @(negedge clk);
            #2;
            cyc++;
            chk("frame_done", frame_done, fd_cur);
            fd_cur = fd_next;
            if (frame_done === 1'b1) begin
                fd_gap = cyc - last_fd_cyc;
                last_fd_cyc = cyc;
            end
            if (out_valid === 1'b1 && out_ready === 1'b1 && !rst && !clr) begin
                if (expq.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_out: got %0d, expected no output", out_data);
                end else begin
                    chk("out_data", out_data, expq.pop_front());
                end
            end
        end

        if (g == 0) begin : t4
            initial begin
                logic acc;
                init();
                // ramp 0..15 -> 5 7 13 15
                ramp(0);
                idle(4);
                // all-negative -16..-1
                ramp(-16);
                idle(4);
                // backpressure: stall after the first output
                for (int i = 0; i < 6; i++) send(DW'(i), 1'b0);
                for (int i = 0; i < 6; i++) step(1'b1, DW'(6), 1'b0, 1'b0, 1'b0, acc);
                for (int i = 6; i < 16; i++) send(DW'(i), 1'b0);
                idle(4);
                // reset mid-frame, then a fresh ramp
                for (int i = 0; i < 6; i++) send(DW'(100 + i), 1'b0);
                idle(3);
                step(1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
                ramp(0);
                idle(4);
                // clr with a same-cycle beat, which must be dropped
                for (int i = 0; i < 3; i++) send(DW'(50 + i), 1'b0);
                step(1'b1, DW'(999), 1'b1, 1'b0, 1'b1, acc);
                ramp(0);
                idle(4);
                // back-to-back frames
                ramp(0);
                ramp(0);
                idle(3);
                chk("fd_gap", DW'(fd_gap), 16);
                rand_frames(3);
                finish_block();
            end
        end else begin : t5
            initial begin
                init();
                // ramp 0..24 -> 6 8 16 18
                ramp(0);
                idle(4);
                rand_frames(2);
                finish_block();
            end
        end
    end

    initial begin
        int i;
        for (i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (h[0].fin && h[1].fin) break;
        end
        chk("all_done", DW'({h[0].fin, h[1].fin}), 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
